hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RISC-V core. Watches the ID, EX, MEM and WB stage fields and produces the following controls:
- stall and flush controls for the IF/ID and ID/EX pipeline registers;
- operand forwarding selects for the EX stage;
- the stall sequence for the multi-cycle multiply/divide unit.

It also keeps free-running stall and flush performance counters. It sits beside the datapath. Its Stall_E output drives the enable of the ID/EX register, and its Bubble_M output clears the EX/MEM register.

---
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage RISC-V core
//   clk, rst                     clock, synchronous active-high reset
//   Rs1_D/Rs2_D, Rs1_E/Rs2_E     source registers in ID and EX
//   Rd_E/RegWrite_E/ResultSrc_E  EX destination, write enable, result source (01 = load)
//   Rd_M/RegWrite_M, Rd_W/RegWrite_W  MEM and WB destinations
//   BranchTaken_E, MulDivStart_E EX redirect and mul/div occupancy
//   CntClr                       clear of both performance counters
//   Stall_F/D/E, Flush_D/E, Bubble_M  pipeline register controls
//   ForwardA_E/ForwardB_E        EX operand selects (00 RF, 01 WB, 10 MEM)
//   MdDone                       mul/div result valid
//   StallCnt/FlushCnt            wrapping performance counters
module hazard_ctrl #(
   parameter int MD_CYCLES = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           Rs1_D,
   input  logic [4:0]           Rs2_D,
   input  logic [4:0]           Rs1_E,
   input  logic [4:0]           Rs2_E,
   input  logic [4:0]           Rd_E,
   input  logic                 RegWrite_E,
   input  logic [1:0]           ResultSrc_E,
   input  logic [4:0]           Rd_M,
   input  logic                 RegWrite_M,
   input  logic [4:0]           Rd_W,
   input  logic                 RegWrite_W,
   input  logic                 BranchTaken_E,
   input  logic                 MulDivStart_E,
   input  logic                 CntClr,
   output logic                 Stall_F,
   output logic                 Stall_D,
   output logic                 Stall_E,
   output logic                 Flush_D,
   output logic                 Flush_E,
   output logic                 Bubble_M,
   output logic [1:0]           ForwardA_E,
   output logic [1:0]           ForwardB_E,
   output logic                 MdDone,
   output logic [CNT_WIDTH-1:0] StallCnt,
   output logic [CNT_WIDTH-1:0] FlushCnt
);
   localparam int CW = $clog2(MD_CYCLES);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic                 stall_md, lu, lu_stall, br_flush;
   always_comb begin
      ForwardA_E = rst ? 2'b00 :
                   (RegWrite_M && Rd_M != 5'd0 && Rd_M == Rs1_E) ? 2'b10 :
                   (RegWrite_W && Rd_W != 5'd0 && Rd_W == Rs1_E) ? 2'b01 : 2'b00;
      ForwardB_E = rst ? 2'b00 :
                   (RegWrite_M && Rd_M != 5'd0 && Rd_M == Rs2_E) ? 2'b10 :
                   (RegWrite_W && Rd_W != 5'd0 && Rd_W == Rs2_E) ? 2'b01 : 2'b00;
   end
   // MulDivStart_E stays high for the whole occupancy, so BUSY ignores it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (MulDivStart_E) begin
            state_d = BUSY;
            cnt_d   = CW'(MD_CYCLES - 2);
         end
      end else if (cnt_q == '0) begin
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end
   // priority: mul/div stall, then branch flush, then load-use
   always_comb begin
      stall_md = !rst && ((state_q == IDLE && MulDivStart_E) || (state_q == BUSY && cnt_q != '0));
      MdDone   = !rst && state_q == BUSY && cnt_q == '0;
      lu       = ResultSrc_E == 2'b01 && RegWrite_E && Rd_E != 5'd0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
      br_flush = !rst && !stall_md && BranchTaken_E;
      lu_stall = !rst && !stall_md && !BranchTaken_E && lu;
      Stall_F  = stall_md || lu_stall;
      Stall_D  = stall_md || lu_stall;
      Stall_E  = stall_md;
      Bubble_M = stall_md;
      Flush_D  = rst || br_flush;
      Flush_E  = rst || br_flush || lu_stall;
      stall_cnt_d = CntClr ? '0 : stall_cnt_q + CNT_WIDTH'(Stall_D);
      flush_cnt_d = CntClr ? '0 : flush_cnt_q + CNT_WIDTH'(br_flush);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table and sequence checks for hazard_ctrl
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
   logic       RegWrite_E, RegWrite_M, RegWrite_W, BranchTaken_E, MulDivStart_E, CntClr;
   logic [1:0] ResultSrc_E, ForwardA_E, ForwardB_E;
   logic       Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M, MdDone;
   logic [3:0] StallCnt, FlushCnt;
   int         n_tests = 0;
   int         n_fail = 0;

   hazard_ctrl #(.MD_CYCLES(4), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
      .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .ResultSrc_E(ResultSrc_E),
      .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
      .BranchTaken_E(BranchTaken_E), .MulDivStart_E(MulDivStart_E), .CntClr(CntClr),
      .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Flush_D(Flush_D),
      .Flush_E(Flush_E), .Bubble_M(Bubble_M), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .MdDone(MdDone), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   // exp packs {ForwardA, ForwardB, Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M}
   typedef struct {
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic       rw_e;
      logic [1:0] rsrc;
      logic [4:0] rd_m;
      logic       rw_m;
      logic [4:0] rd_w;
      logic       rw_w;
      logic       br;
      logic [9:0] exp;
   } vec_t;
   vec_t vecs[13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
      {RegWrite_E, RegWrite_M, RegWrite_W, BranchTaken_E, MulDivStart_E, CntClr} = '0;
      ResultSrc_E = 2'b00;
   endtask

   task automatic set_lu(input logic on);
      ResultSrc_E = on ? 2'b01 : 2'b00;
      RegWrite_E  = on;
      Rd_E        = on ? 5'd7 : 5'd0;
      Rs2_D       = on ? 5'd7 : 5'd0;
   endtask

   function automatic logic [9:0] outs();
      return {ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M};
   endfunction

   initial begin
      vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 10'b10_00_000000};
      vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 10'b01_00_000000};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 10'b00_00_000000};
      vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b0, 2'd0, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 10'b00_01_000000};
      vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 1'b0, 2'd0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 10'b10_10_000000};
      vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 10'b00_00_000000};
      vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b00_00_110010};
      vecs[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b00_00_110010};
      vecs[8]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b00_00_000000};
      vecs[9]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b00_00_000000};
      vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b0, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 10'b00_00_000000};
      vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 10'b00_00_000110};
      vecs[12] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 10'b00_00_000110};

      clear_inputs();
      rst = 1'b1;
      step();
      step();
      // reset: forwarding match present but gated, pipeline flushed
      Rd_M = 5'd5; RegWrite_M = 1'b1; Rs1_E = 5'd5; MulDivStart_E = 1'b1;
      #1;
      chk("rst_outs", int'(outs()), int'(10'b00_00_000110));
      chk("rst_mddone", int'(MdDone), 0);
      step();
      clear_inputs();
      rst = 1'b0;
      #1;
      chk("post_rst_outs", int'(outs()), 0);
      chk("post_rst_stallcnt", int'(StallCnt), 0);
      chk("post_rst_flushcnt", int'(FlushCnt), 0);

      for (int i = 0; i < 13; i++) begin
         {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E} = {vecs[i].rs1_d, vecs[i].rs2_d, vecs[i].rs1_e, vecs[i].rs2_e, vecs[i].rd_e};
         {RegWrite_E, ResultSrc_E, Rd_M, RegWrite_M} = {vecs[i].rw_e, vecs[i].rsrc, vecs[i].rd_m, vecs[i].rw_m};
         {Rd_W, RegWrite_W, BranchTaken_E} = {vecs[i].rd_w, vecs[i].rw_w, vecs[i].br};
         #1;
         chk($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
         step();
      end
      clear_inputs();
      chk("table_stallcnt", int'(StallCnt), 2);
      chk("table_flushcnt", int'(FlushCnt), 2);
      CntClr = 1'b1;
      step();
      CntClr = 1'b0;
      chk("clr_stallcnt", int'(StallCnt), 0);
      chk("clr_flushcnt", int'(FlushCnt), 0);

      // single load-use cycle
      set_lu(1'b1);
      #1;
      chk("lu_outs", int'(outs()), int'(10'b00_00_110010));
      step();
      set_lu(1'b0);
      #1;
      chk("lu_gone_outs", int'(outs()), 0);
      chk("lu_stallcnt", int'(StallCnt), 1);

      // branch overriding load-use
      set_lu(1'b1);
      BranchTaken_E = 1'b1;
      #1;
      chk("br_lu_outs", int'(outs()), int'(10'b00_00_000110));
      step();
      clear_inputs();
      chk("br_lu_flushcnt", int'(FlushCnt), 1);
      chk("br_lu_stallcnt", int'(StallCnt), 1);

      // mul/div: stalls t..t+2, done t+3, back-to-back start at t+4
      MulDivStart_E = 1'b1;
      #1;
      chk("md_t_outs", int'(outs()), int'(10'b00_00_111001));
      chk("md_t_done", int'(MdDone), 0);
      step();
      BranchTaken_E = 1'b1;
      set_lu(1'b1);
      #1;
      chk("md_t1_br_outs", int'(outs()), int'(10'b00_00_111001));
      step();
      BranchTaken_E = 1'b0;
      set_lu(1'b0);
      #1;
      chk("md_t2_outs", int'(outs()), int'(10'b00_00_111001));
      chk("md_t2_done", int'(MdDone), 0);
      step();
      chk("md_t3_outs", int'(outs()), 0);
      chk("md_t3_done", int'(MdDone), 1);
      step();
      chk("md_t4_outs", int'(outs()), int'(10'b00_00_111001));
      chk("md_t4_done", int'(MdDone), 0);
      chk("md_t4_stallcnt", int'(StallCnt), 4);
      chk("md_t4_flushcnt", int'(FlushCnt), 1);
      step();
      step();
      chk("md2_t2_stall", int'(Stall_E), 1);
      step();
      chk("md2_t3_done", int'(MdDone), 1);
      chk("md2_t3_stall", int'(Stall_E), 0);
      step();
      MulDivStart_E = 1'b0;
      #1;
      chk("md2_stallcnt", int'(StallCnt), 7);
      chk("md2_idle_done", int'(MdDone), 0);

      // reset in the middle of a mul/div
      MulDivStart_E = 1'b1;
      step();
      rst = 1'b1;
      #1;
      chk("rst_mid_outs", int'(outs()), int'(10'b00_00_000110));
      chk("rst_mid_done", int'(MdDone), 0);
      step();
      rst = 1'b0;
      #1;
      chk("rst_mid_stallcnt", int'(StallCnt), 0);
      chk("rst_mid_flushcnt", int'(FlushCnt), 0);
      chk("rst_mid_restart", int'(outs()), int'(10'b00_00_111001));
      step();
      step();
      chk("rst_mid_t2_stall", int'(Stall_E), 1);
      step();
      chk("rst_mid_t3_done", int'(MdDone), 1);
      step();
      MulDivStart_E = 1'b0;
      chk("rst_mid_cnt3", int'(StallCnt), 3);

      // wrap at 16 and clear during a stall
      CntClr = 1'b1;
      step();
      CntClr = 1'b0;
      set_lu(1'b1);
      for (int i = 0; i < 15; i++) step();
      chk("wrap_15", int'(StallCnt), 15);
      step();
      chk("wrap_0", int'(StallCnt), 0);
      step();
      step();
      chk("wrap_2", int'(StallCnt), 2);
      CntClr = 1'b1;
      #1;
      chk("clr_in_stall_sd", int'(Stall_D), 1);
      step();
      CntClr = 1'b0;
      set_lu(1'b0);
      chk("clr_in_stall_cnt", int'(StallCnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
